// File: rtl/game_event_fifo_pio.sv
// Avalon-MM event FIFO: fabric pushes event codes, CPU pops them through DATA (optional GAME_EVENT_TIMESTAMP_EN).
// Latency: push visible the cycle after its edge; DATA read is zero-latency and pops at the end of the cycle.
// Backpressure: none toward fabric; a push into a full FIFO is dropped and sets sticky overflow.
module game_event_fifo_pio #(
    parameter int DEPTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              event_valid,
    input  logic [CODE_W-1:0] event_code,
    output logic              irq
);
    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]       DEPTH_C = 9'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [8:0]        r_count;
    logic              r_ovf;
    logic [1:0]        r_mask;

    logic w_rd, w_wr, w_empty, w_full, w_pop, w_flush, w_push, w_drop, w_ovf_clr;
    logic w_unused;

    assign w_rd      = chipselect & ~read_n;
    assign w_wr      = chipselect & ~write_n;
    assign w_empty   = (r_count == 9'd0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_pop     = w_rd && (address == 2'd0) && !w_empty;
    assign w_flush   = w_wr && (address == 2'd3);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push    = event_valid && !w_flush && (!w_full || w_pop);
    assign w_drop    = event_valid && !w_flush && w_full && !w_pop;
    assign w_ovf_clr = w_wr && (address == 2'd1) && writedata[18];
    assign w_unused  = &{1'b0, writedata[31:19], writedata[17:2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_mask   <= 2'b00;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 9'd1;
                    2'b01:   r_count <= r_count - 9'd1;
                    default: r_count <= r_count;
                endcase
            end
            if (w_drop)         r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
            if (w_wr && (address == 2'd2)) r_mask <= writedata[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= event_code;
    end

`ifdef GAME_EVENT_TIMESTAMP_EN
    logic [15:0] r_ts_cnt;
    logic [15:0] r_ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) r_ts_cnt <= 16'd0;
        else       r_ts_cnt <= r_ts_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_ts_mem[r_wr_ptr] <= r_ts_cnt;
    end
`endif

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: begin
                if (!w_empty) begin
                    readdata[31]         = 1'b1;
                    readdata[CODE_W-1:0] = r_mem[r_rd_ptr];
`ifdef GAME_EVENT_TIMESTAMP_EN
                    readdata[23:8]       = r_ts_mem[r_rd_ptr];
`endif
                end
            end
            2'd1: begin
                readdata[8:0] = r_count;
                readdata[16]  = w_empty;
                readdata[17]  = w_full;
                readdata[18]  = r_ovf;
            end
            2'd2:    readdata[1:0] = r_mask;
            default: readdata = 32'd0;
        endcase
    end

    assign irq = (r_mask[0] & ~w_empty) | (r_mask[1] & r_ovf);
endmodule

// File: tb/tb_game_event_fifo_pio.sv
// Directed bench for game_event_fifo_pio: vector table plus hand-written corner sequences.
module tb_game_event_fifo_pio;
    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        event_valid;
    logic [2:0]  event_code;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        ev;
        logic [2:0]  code;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vq[$];

    game_event_fifo_pio #(.DEPTH(8), .CODE_W(3)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .event_valid(event_valid), .event_code(event_code), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] wd,
                                input logic ev, input logic [2:0] code, input logic chk,
                                input logic [31:0] exp_rd, input logic exp_irq);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.ev = ev; v.code = code;
        v.chk = chk; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] wd,
                         input logic ev, input logic [2:0] code);
        chipselect  = (op != OP_IDLE);
        read_n      = (op != OP_RD);
        write_n     = (op != OP_WR);
        address     = addr;
        writedata   = wd;
        event_valid = ev;
        event_code  = code;
    endtask

    // One bus cycle with no checking; returns 1 time unit after the edge.
    task automatic cyc(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] wd,
                       input logic ev, input logic [2:0] code);
        drive(op, addr, wd, ev, code);
        @(posedge clk);
        #1;
        drive(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp,
                          input logic exp_irq);
        drive(OP_RD, addr, 32'd0, 1'b0, 3'd0);
        @(negedge clk);
        check({name, " rdata"}, readdata, exp);
        check({name, " irq"}, {31'd0, irq}, {31'd0, exp_irq});
        @(posedge clk);
        #1;
        drive(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);
    endtask

    initial begin
        // Reset state and simple push/pop
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0001_0000, 0));
        vq.push_back(mk(OP_RD,   2'd0, 0, 0, 0, 1, 32'h0000_0000, 0));
        vq.push_back(mk(OP_IDLE, 2'd0, 0, 1, 5, 1, 32'h0000_0000, 0));
        vq.push_back(mk(OP_IDLE, 2'd0, 0, 1, 2, 1, 32'h8000_0005, 0));
        vq.push_back(mk(OP_IDLE, 2'd0, 0, 1, 7, 1, 32'h8000_0005, 0));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0000_0003, 0));
        vq.push_back(mk(OP_RD,   2'd0, 0, 0, 0, 1, 32'h8000_0005, 0));
        vq.push_back(mk(OP_RD,   2'd0, 0, 0, 0, 1, 32'h8000_0002, 0));
        vq.push_back(mk(OP_RD,   2'd0, 0, 0, 0, 1, 32'h8000_0007, 0));
        vq.push_back(mk(OP_RD,   2'd0, 0, 0, 0, 1, 32'h0000_0000, 0));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0001_0000, 0));
        // Mask register keeps only two bits
        vq.push_back(mk(OP_WR,   2'd2, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
        vq.push_back(mk(OP_RD,   2'd2, 0, 0, 0, 1, 32'h0000_0003, 0));
        vq.push_back(mk(OP_WR,   2'd2, 0, 0, 0, 0, 0, 0));
        // Fill to DEPTH, then one dropped push
        for (int i = 0; i < 8; i++) vq.push_back(mk(OP_IDLE, 2'd0, 0, 1, 3'(i), 0, 0, 0));
        vq.push_back(mk(OP_IDLE, 2'd0, 0, 1, 6, 0, 0, 0));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0006_0008, 0));
        vq.push_back(mk(OP_WR,   2'd2, 32'h2, 0, 0, 0, 0, 0));
        vq.push_back(mk(OP_RD,   2'd2, 0, 0, 0, 1, 32'h0000_0002, 1));
        vq.push_back(mk(OP_WR,   2'd1, 32'h0004_0000, 0, 0, 0, 0, 1));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0002_0008, 0));
        // Full: push and pop together
        vq.push_back(mk(OP_RD,   2'd0, 0, 1, 3, 1, 32'h8000_0000, 0));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0002_0008, 0));
        for (int i = 1; i < 8; i++) vq.push_back(mk(OP_RD, 2'd0, 0, 0, 0, 1, 32'h8000_0000 | 32'(i), 0));
        vq.push_back(mk(OP_RD,   2'd0, 0, 0, 0, 1, 32'h8000_0003, 0));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0001_0000, 0));
        // Non-empty irq, flush beats push
        vq.push_back(mk(OP_WR,   2'd2, 32'h1, 0, 0, 0, 0, 0));
        vq.push_back(mk(OP_IDLE, 2'd0, 0, 1, 4, 1, 32'h0000_0000, 0));
        vq.push_back(mk(OP_WR,   2'd3, 32'h0, 1, 1, 0, 0, 1));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0001_0000, 0));
        vq.push_back(mk(OP_RD,   2'd3, 0, 0, 0, 1, 32'h0000_0000, 0));
        // Empty: push and pop together
        vq.push_back(mk(OP_RD,   2'd0, 0, 1, 6, 1, 32'h0000_0000, 0));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0000_0001, 1));
        vq.push_back(mk(OP_RD,   2'd0, 0, 0, 0, 1, 32'h8000_0006, 1));
        vq.push_back(mk(OP_RD,   2'd1, 0, 0, 0, 1, 32'h0001_0000, 0));
        vq.push_back(mk(OP_WR,   2'd2, 32'h0, 0, 0, 0, 0, 0));

        reset = 1'b1;
        drive(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].op, vq[i].addr, vq[i].wd, vq[i].ev, vq[i].code);
            @(negedge clk);
            if (vq[i].chk) check($sformatf("vec%0d rdata", i), readdata, vq[i].exp_rd);
            check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vq[i].exp_irq});
            @(posedge clk);
            #1;
        end
        drive(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);

        // Overflow set beats clear; flush keeps overflow
        for (int i = 0; i < 8; i++) cyc(OP_IDLE, 2'd0, 32'd0, 1'b1, 3'(i));
        cyc(OP_WR, 2'd1, 32'h0004_0000, 1'b1, 3'd5);
        rd_chk("ovf_set_wins", 2'd1, 32'h0006_0008, 1'b0);
        cyc(OP_WR, 2'd3, 32'h0, 1'b0, 3'd0);
        rd_chk("flush_keeps_ovf", 2'd1, 32'h0005_0000, 1'b0);
        cyc(OP_WR, 2'd1, 32'h0004_0000, 1'b0, 3'd0);
        rd_chk("ovf_cleared", 2'd1, 32'h0001_0000, 1'b0);

        // Reset in the middle of operation
        cyc(OP_WR, 2'd2, 32'h1, 1'b0, 3'd0);
        for (int i = 1; i <= 3; i++) cyc(OP_IDLE, 2'd0, 32'd0, 1'b1, 3'(i));
        rd_chk("pre_reset_count", 2'd1, 32'h0000_0003, 1'b1);
        reset = 1'b1;
        cyc(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);
        reset = 1'b0;
        rd_chk("mid_reset_status", 2'd1, 32'h0001_0000, 1'b0);
        rd_chk("mid_reset_mask", 2'd2, 32'h0000_0000, 1'b0);
        rd_chk("mid_reset_data", 2'd0, 32'h0000_0000, 1'b0);

`ifdef GAME_EVENT_TIMESTAMP_EN
        reset = 1'b1;
        cyc(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);
        reset = 1'b0;
        repeat (16) cyc(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);
        cyc(OP_IDLE, 2'd0, 32'd0, 1'b1, 3'd2);
        rd_chk("ts_0x10", 2'd0, 32'h8000_1002, 1'b0);
        reset = 1'b1;
        cyc(OP_IDLE, 2'd0, 32'd0, 1'b0, 3'd0);
        reset = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        cyc(OP_IDLE, 2'd0, 32'd0, 1'b1, 3'd1);
        rd_chk("ts_wrap", 2'd0, 32'h8000_0000 | (32'(70000 - 65536) << 8) | 32'd1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
